// File: rtl/compare_unit_pkg.sv
// Shared math definitions for compare_unit: FSM state encodings and the
// index-width helper.
package compare_unit_pkg;

    localparam logic [1:0] COMPARE_IDLE = 2'd0;
    localparam logic [1:0] COMPARE_SCAN = 2'd1;
    localparam logic [1:0] COMPARE_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = COMPARE_IDLE,
        ST_SCAN = COMPARE_SCAN,
        ST_DONE = COMPARE_DONE
    } state_t;

    // Ceiling log2, never less than 1 so a single-chunk bus still gets an index bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/compare_unit_if.sv
// Operand and result handshakes of compare_unit. The slave modport is the
// comparator side, the master modport is the producer/consumer side.
interface compare_unit_if #(
    parameter int BUS_SIZE = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [BUS_SIZE-1:0] a;
    logic [BUS_SIZE-1:0] b;
    logic                is_signed;
    logic                out_valid;
    logic                out_ready;
    logic                res_eq;
    logic                res_lt;
    logic                res_gt;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, res_eq, res_lt, res_gt
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, res_eq, res_lt, res_gt
    );
endinterface

// File: rtl/chunk_compare.sv
// Unsigned equality / less-than on one CHUNK_SIZE-bit slice of the operands.
module chunk_compare #(
    parameter int CHUNK_SIZE = 8
) (
    input  logic [CHUNK_SIZE-1:0] i_a,
    input  logic [CHUNK_SIZE-1:0] i_b,
    output logic                  chunk_eq,
    output logic                  chunk_lt
);
    assign chunk_eq = (i_a == i_b);
    assign chunk_lt = (i_a < i_b);
endmodule

// File: rtl/compare_unit.sv
// Multi-cycle magnitude/equality comparator: scans the operands one chunk per
// cycle from the top, stopping at the first differing chunk.
module compare_unit
    import compare_unit_pkg::*;
#(
    parameter int BUS_SIZE   = 32,
    parameter int CHUNK_SIZE = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    compare_unit_if.slave  bus
);
    localparam int                    NCHUNK    = BUS_SIZE / CHUNK_SIZE;
    localparam int                    IDX_W     = clog2_min1(NCHUNK);
    localparam logic [IDX_W-1:0]      IDX_TOP   = IDX_W'(NCHUNK - 1);
    localparam logic [BUS_SIZE-1:0]   SIGN_MASK = {1'b1, {(BUS_SIZE-1){1'b0}}};

    state_t                r_state;
    state_t                w_state_next;
    logic [BUS_SIZE-1:0]   r_opa;
    logic [BUS_SIZE-1:0]   r_opb;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_eq;
    logic                  r_lt;
    logic                  r_gt;
    logic [CHUNK_SIZE-1:0] w_chunk_a;
    logic [CHUNK_SIZE-1:0] w_chunk_b;
    logic                  w_chunk_eq;
    logic                  w_chunk_lt;

    assign w_chunk_a = CHUNK_SIZE'(r_opa >> (int'(r_idx) * CHUNK_SIZE));
    assign w_chunk_b = CHUNK_SIZE'(r_opb >> (int'(r_idx) * CHUNK_SIZE));

    chunk_compare #(.CHUNK_SIZE(CHUNK_SIZE)) u_chunk_compare (
        .i_a      (w_chunk_a),
        .i_b      (w_chunk_b),
        .chunk_eq (w_chunk_eq),
        .chunk_lt (w_chunk_lt)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (!w_chunk_eq || (r_idx == '0)) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Flipping the sign bits maps two's-complement order onto unsigned order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa <= '0;
            r_opb <= '0;
            r_idx <= '0;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
            r_gt  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_opa <= bus.a ^ (bus.is_signed ? SIGN_MASK : '0);
                        r_opb <= bus.b ^ (bus.is_signed ? SIGN_MASK : '0);
                        r_idx <= IDX_TOP;
                    end
                end
                ST_SCAN: begin
                    if (!w_chunk_eq) begin
                        r_eq <= 1'b0;
                        r_lt <= w_chunk_lt;
                        r_gt <= !w_chunk_lt;
                    end else if (r_idx == '0) begin
                        r_eq <= 1'b1;
                        r_lt <= 1'b0;
                        r_gt <= 1'b0;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.res_eq = r_eq;
    assign bus.res_lt = r_lt;
    assign bus.res_gt = r_gt;

endmodule

// File: tb/tb_compare_unit.sv
// Directed bench for compare_unit: a reference model derives flags and latency
// from the operands, and a negedge monitor checks every valid result.
module tb_compare_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    compare_unit_if #(.BUS_SIZE(32)) bus_if ();

    compare_unit #(.BUS_SIZE(32), .CHUNK_SIZE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    int         n_tests    = 0;
    int         n_fail     = 0;
    logic [2:0] exp_flags  = 3'b000;
    logic       exp_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [2:0] flags_now();
        return {bus_if.res_eq, bus_if.res_lt, bus_if.res_gt};
    endfunction

    // Flags {eq,lt,gt} from plain arithmetic; latency = chunks down to the first difference.
    function automatic void model(input logic [31:0] ta, input logic [31:0] tb_op,
                                  input logic ts, output logic [2:0] flags, output int lat);
        logic found;
        found = 1'b0;
        lat   = 4;
        for (int i = 3; i >= 0; i--) begin
            if (!found && (ta[i*8 +: 8] != tb_op[i*8 +: 8])) begin
                found = 1'b1;
                lat   = 4 - i;
            end
        end
        if (ta == tb_op)                                       flags = 3'b100;
        else if (ts ? ($signed(ta) < $signed(tb_op)) : (ta < tb_op)) flags = 3'b010;
        else                                                   flags = 3'b001;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus_if.out_valid) begin
            check("mon_onehot", 32'($countones(flags_now())), 32'd1);
            check("mon_in_ready_low", {31'd0, bus_if.in_ready}, 32'd0);
            if (exp_active) check("mon_flags", {29'd0, flags_now()}, {29'd0, exp_flags});
        end
    end

    task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb_op,
                       input logic ts, input logic [2:0] lit_flags, input int lit_lat,
                       input int backp);
        logic [2:0] mf;
        int         ml;
        int         cnt;
        model(ta, tb_op, ts, mf, ml);
        check({tag, "_model_flags"}, {29'd0, mf}, {29'd0, lit_flags});
        check({tag, "_model_lat"}, 32'(ml), 32'(lit_lat));
        exp_flags  = mf;
        exp_active = 1'b1;

        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, bus_if.in_ready}, 32'd1);
        bus_if.in_valid  = 1'b1;
        bus_if.a         = ta;
        bus_if.b         = tb_op;
        bus_if.is_signed = ts;
        @(posedge clk); #1;
        bus_if.in_valid  = 1'b0;
        bus_if.a         = ~ta;
        bus_if.b         = ta ^ 32'h5A5A_5A5A;
        bus_if.is_signed = ~ts;

        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!bus_if.out_valid && cnt < 40);
        check({tag, "_latency"}, 32'(cnt), 32'(ml));

        for (int k = 0; k < backp; k++) begin
            check({tag, "_bp_in_ready"}, {31'd0, bus_if.in_ready}, 32'd0);
            check({tag, "_bp_out_valid"}, {31'd0, bus_if.out_valid}, 32'd1);
            check({tag, "_bp_flags"}, {29'd0, flags_now()}, {29'd0, mf});
            if (k == 1) begin
                bus_if.in_valid = 1'b1;
                bus_if.a        = 32'hDEAD_BEEF;
                bus_if.b        = 32'h0000_0001;
            end
            @(posedge clk); #1;
            bus_if.in_valid = 1'b0;
        end

        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        check({tag, "_post_in_ready"}, {31'd0, bus_if.in_ready}, 32'd1);
        check({tag, "_post_out_valid"}, {31'd0, bus_if.out_valid}, 32'd0);
        check({tag, "_flags_held"}, {29'd0, flags_now()}, {29'd0, mf});
        exp_active = 1'b0;
    endtask

    task automatic reset_mid_scan();
        exp_active = 1'b0;
        @(negedge clk);
        bus_if.in_valid  = 1'b1;
        bus_if.a         = 32'h1234_5678;
        bus_if.b         = 32'h1234_5678;
        bus_if.is_signed = 1'b0;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        check("rst_pre_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("rst_async_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("rst_async_flags", {29'd0, flags_now()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_after_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.is_signed = 1'b0;
        bus_if.out_ready = 1'b0;
        #12;
        check("reset_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("reset_flags", {29'd0, flags_now()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("eq_u",       32'h1234_5678, 32'h1234_5678, 1'b0, 3'b100, 4, 0);
        run("lt_top_u",   32'h0100_0000, 32'h0200_0000, 1'b0, 3'b010, 1, 0);
        run("neg_s",      32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b010, 1, 0);
        run("big_u",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b001, 1, 0);
        run("gt_low_bp",  32'h0000_00FF, 32'h0000_00FE, 1'b0, 3'b001, 4, 3);
        run("min_max_s",  32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b010, 1, 0);
        run("near_neg_s", 32'hFFFF_FF00, 32'hFFFF_FF01, 1'b1, 3'b010, 4, 0);

        reset_mid_scan();

        run("post_rst_u", 32'h0000_1234, 32'h0000_1200, 1'b0, 3'b001, 4, 0);
        run("mid_s",      32'h0012_0000, 32'h0013_0000, 1'b1, 3'b010, 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/compare_unit.md
# compare_unit

Multi-cycle magnitude/equality comparator in the math block. It accepts two operands through a valid/ready handshake and scans them CHUNK_SIZE bits per cycle, from the most significant chunk down, stopping at the first differing chunk. It returns registered eq/lt/gt flags through a second valid/ready handshake. Its consumer is the flags/branch-condition logic of the CPU.

## Interface
- BUS_SIZE, 32, operand width
- CHUNK_SIZE, 8, bits compared per cycle; must divide BUS_SIZE
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands and mode are present
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  BUS_SIZE  left operand
- b  input  BUS_SIZE  right operand
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned
- out_valid  output  1  result flags are valid
- out_ready  input  1  consumer takes the result
- res_eq  output  1  a == b
- res_lt  output  1  a < b under the selected mode
- res_gt  output  1  a > b under the selected mode

## Operation
- Derived constants:
  - NCHUNK = BUS_SIZE/CHUNK_SIZE.
  - Chunk index width = clog2(NCHUNK), minimum 1.
- States are IDLE, SCAN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at a clock edge, latch a and b into opa/opb. When is_signed = 1, invert bit BUS_SIZE-1 of both latched copies.
  - Set idx = NCHUNK-1 and go to SCAN.
- SCAN:
  - in_ready = 0.
  - Compare chunk idx of opa and opb as unsigned values.
  - Chunk differs: register res_eq = 0, res_lt = chunk_lt, res_gt = !chunk_lt, then go to DONE.
  - Chunk equal and idx == 0: register res_eq = 1, res_lt = 0, res_gt = 0, then go to DONE.
  - Chunk equal and idx > 0: decrement idx and stay in SCAN.
- DONE:
  - out_valid = 1.
  - On out_ready, go to IDLE.
  - Flags keep their last value after the handshake until the next result is registered.
- Invariant: when out_valid = 1, exactly one of res_eq, res_lt, res_gt is 1.
- Input side:
  - in_valid while busy is ignored; the upstream stage must hold its operands until in_ready.
  - a, b and is_signed are sampled only on the accept edge.

## Timing
- Reset (asynchronous, immediate on rst_n low, from any state including mid-SCAN or DONE):
  - state = IDLE, in_ready = 1, out_valid = 0.
  - res_eq = res_lt = res_gt = 0.
  - opa = opb = 0, idx = 0.
  - Any in-flight operation is discarded.
- Latency (E0 = accept edge):
  - out_valid rises m edges after E0, where m = number of chunks scanned, 1..NCHUNK.
  - Worst case is NCHUNK edges (equal operands, or a difference only in chunk 0).
- Back-to-back operation:
  - The DONE→IDLE transition takes one edge, and in_ready is high the cycle after the output handshake.
  - Minimum initiation interval is m+2 cycles.
- Backpressure: out_valid and the flags are stable while out_ready = 0, for any number of cycles.
- CHUNK_SIZE == BUS_SIZE: every compare takes one SCAN cycle.

## Structure
- Shared math include file holds:
  - the state encodings COMPARE_IDLE, COMPARE_SCAN, COMPARE_DONE (2-bit);
  - the clog2 helper used for the index width.
- Sub-module chunk_compare:
  - purely combinational, parameter CHUNK_SIZE;
  - outputs chunk_eq and chunk_lt (unsigned).
- One instance of chunk_compare is fed by the chunk selected with idx.
- Everything else (FSM, operand registers, flag registers) lives in compare_unit.

## Test plan
- Defaults 32/8 are used throughout; latency is counted in edges after E0.
- a = b = 0x12345678, is_signed = 0 → res_eq = 1, res_lt = 0, res_gt = 0; out_valid exactly 4 edges after E0.
- a = 0x01000000, b = 0x02000000, unsigned → res_lt = 1; out_valid 1 edge after E0.
- a = 0xFFFFFFFF, b = 0x00000001:
  - signed → res_lt = 1, latency 1;
  - same operands unsigned → res_gt = 1, latency 1.
- a = 0x000000FF, b = 0x000000FE → res_gt = 1, latency 4.
- Backpressure: out_ready held low for 3 cycles in DONE, with in_valid pulsed meanwhile. Required:
  - flags and out_valid stay constant and in_ready stays 0;
  - the pulse is not captured;
  - after out_ready goes high, in_ready = 1 one cycle later.
- rst_n asserted during the second SCAN cycle of an equal-operand compare → in_ready = 1 and out_valid = 0 with all flags 0 immediately (asynchronous). A new compare after reset release produces the correct result.
